demultiplexeur_tdm_8bitx4: RTL and testbench

Receive-end counterpart of the 4-way multiplexer datapath. It takes a time-division-multiplexed word stream, in which one sender word per beat cycles through four slots with slot 0 tagged by frame_sync. It routes each beat to one of four registered channel outputs and tracks frame alignment with a two-state lock FSM. It sits between a mux-based TDM link and the four per-channel consumers.

---
 rtl/demultiplexeur_tdm_8bitx4.sv | 112 +++++++++++
 tb/tb_demultiplexeur_tdm_8bitx4.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/demultiplexeur_tdm_8bitx4.sv
// TDM receive demux: routes one beat per cycle into four channel registers, tracks frame lock.
// Outputs registered (1-cycle latency); no backpressure. Optional parity check: DEMUX_TDM_PARITY_EN.
module demultiplexeur_tdm_8bitx4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
`ifdef DEMUX_TDM_PARITY_EN
    input  logic             din_parity,
    output logic             parity_err,
`endif
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic [3:0]       ch_valid,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [1:0]       slot, slot_nxt;
    logic             wr_req;
    logic [1:0]       wr_slot;
    logic             err_nxt;
    logic             beat_ok;
    logic             wr_en;
    logic [WIDTH-1:0] ch_q [4];

`ifdef DEMUX_TDM_PARITY_EN
    assign beat_ok = ~^{din, din_parity};
`else
    assign beat_ok = 1'b1;
`endif

    // A sync beat always restarts the frame at slot 0, whatever the current slot.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        wr_req    = 1'b0;
        wr_slot   = 2'd0;
        err_nxt   = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        wr_req    = 1'b1;
                        slot_nxt  = 2'd1;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        wr_req   = 1'b1;
                        slot_nxt = 2'd1;
                        err_nxt  = (slot != 2'd0);
                    end else if (slot == 2'd0) begin
                        err_nxt   = 1'b1;
                        slot_nxt  = 2'd0;
                        state_nxt = HUNT;
                    end else begin
                        wr_req   = 1'b1;
                        wr_slot  = slot;
                        slot_nxt = slot + 2'd1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign wr_en = wr_req & beat_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            slot       <= 2'd0;
            ch_valid   <= 4'd0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            for (int i = 0; i < 4; i++) ch_q[i] <= '0;
        end else begin
            state      <= state_nxt;
            slot       <= slot_nxt;
            ch_valid   <= wr_en ? (4'b0001 << wr_slot) : 4'd0;
            frame_done <= wr_en && (wr_slot == 2'd3);
            sync_err   <= err_nxt;
            if (wr_en) ch_q[wr_slot] <= din;
        end
    end

`ifdef DEMUX_TDM_PARITY_EN
    // Bad-parity beats still advance slot/FSM so alignment survives a corrupted word.
    always_ff @(posedge clk) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= wr_req & ~beat_ok;
    end
`endif

    assign locked = (state == LOCKED);
    assign ch0    = ch_q[0];
    assign ch1    = ch_q[1];
    assign ch2    = ch_q[2];
    assign ch3    = ch_q[3];

endmodule

// File: tb/tb_demultiplexeur_tdm_8bitx4.sv
// Bench for demultiplexeur_tdm_8bitx4: directed frames plus random beats against a frame-level model.
module tb_demultiplexeur_tdm_8bitx4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic [3:0] ch_valid;
    logic       frame_done, locked, sync_err;
`ifdef DEMUX_TDM_PARITY_EN
    logic       din_parity;
    logic       parity_err;
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    demultiplexeur_tdm_8bitx4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
`ifdef DEMUX_TDM_PARITY_EN
        .din_parity (din_parity),
        .parity_err (parity_err),
`endif
        .ch0        (ch0),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: channel contents, pulses expected after the last edge, lock and frame position.
    logic [7:0] m_ch [4];
    int         m_vld;
    bit         m_fd, m_lk, m_se, m_pe;
    int         m_slot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int s, input logic [7:0] d, input bit good);
        if (good) begin
            m_ch[s] = d;
            m_vld   = 1 << s;
            m_fd    = (s == 3);
        end else begin
            m_pe = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit v, input bit fs, input logic [7:0] d, input bit p);
        bit good;
        reset      = r;
        din_valid  = v;
        frame_sync = fs;
        din        = d;
`ifdef DEMUX_TDM_PARITY_EN
        din_parity = p;
`endif
        good = !PAR_ON || ((^d) == p);
        @(posedge clk);
        #1;
        m_vld = 0; m_fd = 0; m_se = 0; m_pe = 0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
            m_lk = 0; m_slot = 0;
        end else if (v) begin
            if (!m_lk) begin
                if (fs) begin
                    model_write(0, d, good);
                    m_lk = 1; m_slot = 1;
                end
            end else if (fs) begin
                m_se = (m_slot != 0);
                model_write(0, d, good);
                m_slot = 1;
            end else if (m_slot == 0) begin
                m_se = 1; m_lk = 0;
            end else begin
                model_write(m_slot, d, good);
                m_slot = (m_slot + 1) % 4;
            end
        end
        check("ch0", 32'(ch0), 32'(m_ch[0]));
        check("ch1", 32'(ch1), 32'(m_ch[1]));
        check("ch2", 32'(ch2), 32'(m_ch[2]));
        check("ch3", 32'(ch3), 32'(m_ch[3]));
        check("ch_valid", 32'(ch_valid), 32'(m_vld));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("locked", 32'(locked), 32'(m_lk));
        check("sync_err", 32'(sync_err), 32'(m_se));
`ifdef DEMUX_TDM_PARITY_EN
        check("parity_err", 32'(parity_err), 32'(m_pe));
`endif
    endtask

    function automatic bit par(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        logic [7:0] t1 [8];
        logic [7:0] d;
        bit         v, fs, r, p;
        t1 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};

        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        check("rst_ch_valid", 32'(ch_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        // Two clean frames.
        for (int i = 0; i < 8; i++) step(0, 1, (i % 4) == 0, t1[i], par(t1[i]));
        check("t1_ch0", 32'(ch0), 32'h20);
        check("t1_ch3", 32'(ch3), 32'h23);
        check("t1_fd", 32'(frame_done), 32'd1);

        // Unsynced beats in HUNT, then lock.
        step(0, 1, 0, 8'h77, par(8'h77));
        check("t4_locked", 32'(locked), 32'd0);
        step(0, 1, 0, 8'hAA, par(8'hAA));
        step(0, 0, 1, 8'hEE, par(8'hEE));
        step(0, 1, 0, 8'hBB, par(8'hBB));
        step(0, 1, 0, 8'hCC, par(8'hCC));
        check("t2_locked", 32'(locked), 32'd0);
        step(0, 1, 1, 8'h01, par(8'h01));
        check("t2_ch0", 32'(ch0), 32'h01);
        check("t2_locked_after", 32'(locked), 32'd1);

        // Early sync after slot 1.
        step(0, 1, 0, 8'h02, par(8'h02));
        step(0, 1, 1, 8'h55, par(8'h55));
        check("t3_sync_err", 32'(sync_err), 32'd1);
        check("t3_ch0", 32'(ch0), 32'h55);
        check("t3_ch_valid", 32'(ch_valid), 32'd1);
        step(0, 1, 0, 8'h66, par(8'h66));
        check("t3_ch1", 32'(ch1), 32'h66);

        // Reset after slot 2 of a frame.
        step(0, 1, 0, 8'h67, par(8'h67));
        step(0, 1, 1, 8'h30, par(8'h30));
        step(0, 1, 0, 8'h31, par(8'h31));
        step(0, 1, 0, 8'h32, par(8'h32));
        step(1, 1, 0, 8'h33, par(8'h33));
        check("t5_ch2", 32'(ch2), 32'd0);
        step(0, 1, 0, 8'h44, par(8'h44));
        check("t5_locked", 32'(locked), 32'd0);

`ifdef DEMUX_TDM_PARITY_EN
        step(0, 1, 1, 8'h40, par(8'h40));
        step(0, 1, 0, 8'h03, 1'b1);
        check("t6_parity_err", 32'(parity_err), 32'd1);
        check("t6_ch_valid", 32'(ch_valid), 32'd0);
        step(0, 1, 0, 8'h42, par(8'h42));
        check("t6_ch2", 32'(ch2), 32'h42);
`endif

        // Random traffic, mostly aligned, with occasional sync faults, idles and resets.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if (!m_lk || m_slot == 0) fs = ($urandom_range(0, 9) != 0);
            else                      fs = ($urandom_range(0, 19) == 0);
            d  = 8'($urandom);
            p  = par(d) ^ ($urandom_range(0, 15) == 0);
            step(r, v, fs, d, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
